// File: rtl/bcd_sevenseg_scan_if.sv
// Display-side bundle for bcd_sevenseg_scan: BCD load path in, anode/segment pins out.
// The CPU side takes the master modport and the scanner takes the slave modport.
interface bcd_sevenseg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [39:0]           bcd_in;
  logic                  load;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  ovf;

  modport master (
    output bcd_in,
    output load,
    input  an,
    input  seg,
    input  dp,
    input  ovf
  );

  modport slave (
    input  bcd_in,
    input  load,
    output an,
    output seg,
    output dp,
    output ovf
  );
endinterface

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver fed from a 40-bit packed BCD snapshot.
// Define SEVSEG_BLANK_EN to suppress leading zeros (digit 0 is always shown).
module bcd_sevenseg_scan #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input logic                clk,
  input logic                rst,
  bcd_sevenseg_scan_if.slave bus
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(REFRESH_CYCLES);
  localparam int DISP_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  logic [DISP_W-1:0]     disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  phase_t                phase_q, phase_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  ovfIn;
  logic                  cntWrap;
  logic [3:0]            curNibble;

  function automatic logic [6:0] decodeDigit(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b0111111;
    endcase
    return pattern;
  endfunction

  // Any non-zero BCD digit above the physical digit count means the value cannot be shown.
  generate
    if (NUM_DIGITS < 10) begin : gOvf
      assign ovfIn = |bus.bcd_in[39:DISP_W];
    end else begin : gNoOvf
      assign ovfIn = 1'b0;
    end
  endgenerate

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (bus.load) begin
      disp_d = bus.bcd_in[DISP_W-1:0];
      ovf_d  = ovfIn;
    end
  end

  always_comb begin
    cntWrap = (cnt_q == CNT_MAX);
    cnt_d   = cntWrap ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    if (cntWrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Anodes stay dark for the first BLANK_CYCLES of every slot so the previous digit cannot ghost.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_BLANK: if (cnt_d == CNT_BLANK) phase_d = PH_ON;
      PH_ON:    if (cntWrap) phase_d = PH_BLANK;
      default:  phase_d = PH_BLANK;
    endcase
  end

  assign curNibble = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEVSEG_BLANK_EN
  logic [IDX_W-1:0] msdIdx;

  always_comb begin
    msdIdx = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (disp_q[4*k +: 4] != 4'd0) begin
        msdIdx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    seg_d = decodeDigit(curNibble);
    if (idx_q > msdIdx) begin
      seg_d = 7'h7F;
    end
  end
`else
  always_comb begin
    seg_d = decodeDigit(curNibble);
  end
`endif

  always_comb begin
    an_d = '1;
    if (phase_q == PH_ON) begin
      an_d[idx_q] = 1'b0;
    end
    dp_d = ~(ovf_q && (idx_q == IDX_MAX) && (phase_q == PH_ON));
  end

  // Pin drivers are registered, so they trail the scan state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      phase_q <= PH_BLANK;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Directed self-checking bench for bcd_sevenseg_scan with a short 4-cycle slot and 1-cycle blank.
// Expected pins come from a cycle model of the scan position and the decode table.
module tb_bcd_sevenseg_scan;

  localparam int NUM_DIGITS     = 8;
  localparam int REFRESH_CYCLES = 4;
  localparam int BLANK_CYCLES   = 1;

  logic clock = 1'b0;
  logic reset;

  int checkCount = 0;
  int errorCount = 0;
  int edgeCount  = 0;

  logic [31:0] dispModel;
  logic        ovfModel;

  bcd_sevenseg_scan_if #(.NUM_DIGITS(NUM_DIGITS)) dispBus ();

  bcd_sevenseg_scan #(
    .NUM_DIGITS    (NUM_DIGITS),
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .BLANK_CYCLES  (BLANK_CYCLES)
  ) dut (
    .clk(clock),
    .rst(reset),
    .bus(dispBus)
  );

  always #5 clock = ~clock;

  // Single comparison point: every check is counted here and mismatches are reported once.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [6:0] segExp(input logic [31:0] value, input int digit);
    logic [3:0] nibble;
    int         msd;
    logic [6:0] pattern;
    nibble = value[digit*4 +: 4];
    msd    = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (value[k*4 +: 4] != 4'd0) msd = k;
    end
    case (nibble)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b0111111;
    endcase
`ifdef SEVSEG_BLANK_EN
    if (digit > msd) pattern = 7'h7F;
`else
    if (msd < 0) pattern = 7'h00;
`endif
    return pattern;
  endfunction

  // Advance n clock edges, checking every pin against the scan position held before each edge.
  task automatic stepCheck(input int n);
    int          sIdx;
    int          sCnt;
    logic [31:0] prevDisp;
    logic        prevOvf;
    logic [7:0]  anExp;
    logic        dpExp;
    for (int i = 0; i < n; i++) begin
      sCnt     = edgeCount % REFRESH_CYCLES;
      sIdx     = (edgeCount / REFRESH_CYCLES) % NUM_DIGITS;
      prevDisp = dispModel;
      prevOvf  = ovfModel;
      if (dispBus.load) begin
        dispModel = dispBus.bcd_in[31:0];
        ovfModel  = |dispBus.bcd_in[39:32];
      end
      @(posedge clock);
      edgeCount++;
      #1;
      anExp = (sCnt < BLANK_CYCLES) ? 8'hFF : ~(8'h01 << sIdx);
      dpExp = (prevOvf && (sIdx == NUM_DIGITS - 1) && (sCnt >= BLANK_CYCLES)) ? 1'b0 : 1'b1;
      checkOutput("an",  32'(dispBus.an),  32'(anExp));
      checkOutput("seg", 32'(dispBus.seg), 32'(segExp(prevDisp, sIdx)));
      checkOutput("dp",  32'(dispBus.dp),  32'(dpExp));
      checkOutput("ovf", 32'(dispBus.ovf), 32'(ovfModel));
    end
  endtask

  // One-cycle load pulse; bcd_in is then parked on a pattern that must not be captured.
  task automatic applyStimulus(input logic [39:0] value);
    dispBus.bcd_in = value;
    dispBus.load   = 1'b1;
    stepCheck(1);
    dispBus.load   = 1'b0;
    dispBus.bcd_in = 40'hFFFFFFFFFF;
  endtask

  task automatic checkResetPins(input string tag);
    checkOutput({tag, "_an"},  32'(dispBus.an),  32'h0000_00FF);
    checkOutput({tag, "_seg"}, 32'(dispBus.seg), 32'h0000_007F);
    checkOutput({tag, "_dp"},  32'(dispBus.dp),  32'h0000_0001);
    checkOutput({tag, "_ovf"}, 32'(dispBus.ovf), 32'h0000_0000);
  endtask

  task automatic releaseReset();
    reset     = 1'b0;
    edgeCount = 0;
    dispModel = '0;
    ovfModel  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    dispBus.load   = 1'b0;
    dispBus.bcd_in = '0;
    repeat (2) @(posedge clock);
    #1;
    checkResetPins("reset");
    releaseReset();

    $display("[TB] scan with no load");
    stepCheck(1);
    checkOutput("firstBlank", 32'(dispBus.an), 32'h0000_00FF);
    stepCheck(1);
    checkOutput("firstOn", 32'(dispBus.an), 32'h0000_00FE);
    stepCheck(32);

    $display("[TB] load 0012345678");
    applyStimulus(40'h0012345678);
    stepCheck(33);

    $display("[TB] mid-slot load at digit 3");
    for (int i = 0; i < 32 && (edgeCount % 32) != 13; i++) stepCheck(1);
    checkOutput("midAlign", 32'(edgeCount % 32), 32'd13);
    dispBus.bcd_in = 40'h0000000001;
    dispBus.load   = 1'b1;
    stepCheck(1);
    dispBus.load   = 1'b0;
    checkOutput("midOldSeg", 32'(dispBus.seg), 32'h0000_0012);
    checkOutput("midAn", 32'(dispBus.an), 32'h0000_00F7);
    stepCheck(1);
`ifdef SEVSEG_BLANK_EN
    checkOutput("midNewSeg", 32'(dispBus.seg), 32'h0000_007F);
`else
    checkOutput("midNewSeg", 32'(dispBus.seg), 32'h0000_0040);
`endif
    stepCheck(10);

    $display("[TB] load 0090000000");
    applyStimulus(40'h0090000000);
    stepCheck(33);

    $display("[TB] load 0100000003 overflow");
    applyStimulus(40'h0100000003);
    checkOutput("ovfSet", 32'(dispBus.ovf), 32'h0000_0001);
    stepCheck(33);

    $display("[TB] load 000000000A invalid digit");
    applyStimulus(40'h000000000A);
    stepCheck(33);

    $display("[TB] async reset mid ON slot");
    applyStimulus(40'h0100000003);
    for (int i = 0; i < 4 && (edgeCount % 4) != 2; i++) stepCheck(1);
    checkOutput("rstAlignAn", 32'(dispBus.an == 8'hFF), 32'h0);
    #3;
    reset = 1'b1;
    #1;
    checkResetPins("asyncRst");
    @(posedge clock);
    #1;
    checkResetPins("heldRst");
    releaseReset();
    stepCheck(10);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
